// File: rtl/gps_dump_buffer.sv
// Record FIFO for tracking-channel dumps: each dump becomes a 4-word record
// that firmware drains one 32-bit word at a time, with sticky overflow and level irq.
module gps_dump_buffer #(
    parameter int DEPTH     = 8,
    parameter int IRQ_LEVEL = 1
) (
    input  logic        correlator_clk,
    input  logic        correlator_rst,
    input  logic        dump,
    input  logic [15:0] i_early,
    input  logic [15:0] q_early,
    input  logic [15:0] i_prompt,
    input  logic [15:0] q_prompt,
    input  logic [15:0] i_late,
    input  logic [15:0] q_late,
    input  logic [10:0] epoch,
    input  logic        flush,
    input  logic        clr_ovf,
    input  logic        rd_pop,
    output logic [31:0] rd_data,
    output logic [1:0]  rd_word,
    output logic [5:0]  level,
    output logic        empty,
    output logic        full,
    output logic        overflow,
    output logic        irq
);
    localparam int         PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [5:0] LVL_FULL = 6'(DEPTH);
    localparam logic [5:0] LVL_IRQ  = 6'(IRQ_LEVEL);

    logic [3:0][31:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [4:0]       seq;
    logic             retire, accept, drop;

    assign empty  = (level == '0);
    assign full   = (level == LVL_FULL);
    assign irq    = (level >= LVL_IRQ);

    // A retire frees the head slot in the same edge, so a dump into a full buffer still lands.
    assign retire = rd_pop & ~empty & (rd_word == 2'd3);
    assign accept = dump & ~flush & (~full | retire);
    assign drop   = dump & ~flush & full & ~retire;

    assign rd_data = empty ? 32'h0 : mem[rd_ptr][rd_word];

    always_ff @(posedge correlator_clk) begin
        if (accept)
            mem[wr_ptr] <= {16'h0, seq, epoch,
                            i_late, q_late,
                            i_prompt, q_prompt,
                            i_early, q_early};
    end

    always_ff @(posedge correlator_clk) begin
        if (correlator_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rd_word  <= '0;
            seq      <= '0;
            overflow <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                level   <= '0;
                rd_word <= '0;
                seq     <= '0;
            end else begin
                // rd_word wraps 3->0 exactly when the head retires
                if (rd_pop && !empty) rd_word <= rd_word + 2'd1;
                if (retire)           rd_ptr  <= rd_ptr + PW'(1);
                if (accept)           wr_ptr  <= wr_ptr + PW'(1);
                case ({accept, retire})
                    2'b10:   level <= level + 6'd1;
                    2'b01:   level <= level - 6'd1;
                    default: level <= level;
                endcase
                if (dump) seq <= seq + 5'd1;
            end
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_gps_dump_buffer.sv
// Directed and randomized checks of gps_dump_buffer against a queue-based record model.
module tb_gps_dump_buffer;
    localparam int DEPTH     = 8;
    localparam int IRQ_LEVEL = 1;

    logic        correlator_clk = 1'b0;
    logic        correlator_rst = 1'b1;
    logic        dump = 1'b0, flush = 1'b0, clr_ovf = 1'b0, rd_pop = 1'b0;
    logic [15:0] i_early = '0, q_early = '0, i_prompt = '0, q_prompt = '0, i_late = '0, q_late = '0;
    logic [10:0] epoch = '0;
    logic [31:0] rd_data;
    logic [1:0]  rd_word;
    logic [5:0]  level;
    logic        empty, full, overflow, irq;

    gps_dump_buffer #(.DEPTH(DEPTH), .IRQ_LEVEL(IRQ_LEVEL)) dut (
        .correlator_clk(correlator_clk), .correlator_rst(correlator_rst),
        .dump(dump), .i_early(i_early), .q_early(q_early),
        .i_prompt(i_prompt), .q_prompt(q_prompt), .i_late(i_late), .q_late(q_late),
        .epoch(epoch), .flush(flush), .clr_ovf(clr_ovf), .rd_pop(rd_pop),
        .rd_data(rd_data), .rd_word(rd_word), .level(level),
        .empty(empty), .full(full), .overflow(overflow), .irq(irq)
    );

    always #5 correlator_clk = ~correlator_clk;

    // reference model: queue of whole records, word 0 in the low 32 bits
    logic [127:0] q[$];
    int           m_rw  = 0;
    int           m_seq = 0;
    logic         m_ovf = 1'b0;
    int           n_cmp = 0;
    int           n_fail = 0;
    logic [15:0]  saved_i, saved_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic ret, drp;
        if (correlator_rst) begin
            q.delete(); m_rw = 0; m_seq = 0; m_ovf = 1'b0;
            return;
        end
        drp = 1'b0;
        if (flush) begin
            q.delete(); m_rw = 0; m_seq = 0;
        end else begin
            ret = 1'b0;
            if (rd_pop && q.size() > 0) begin
                if (m_rw == 3) begin ret = 1'b1; m_rw = 0; void'(q.pop_front()); end
                else m_rw++;
            end
            if (dump) begin
                if (q.size() < DEPTH)
                    q.push_back({16'h0, 5'(m_seq), epoch, i_late, q_late,
                                 i_prompt, q_prompt, i_early, q_early});
                else drp = 1'b1;
                m_seq = (m_seq + 1) % 32;
            end
        end
        if (drp) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
    endtask

    task automatic check_all();
        logic [127:0] h;
        logic [31:0]  exp_d;
        exp_d = 32'h0;
        if (q.size() > 0) begin h = q[0]; exp_d = h[m_rw*32 +: 32]; end
        chk("level",    32'(level),    32'(q.size()));
        chk("empty",    32'(empty),    32'(q.size() == 0));
        chk("full",     32'(full),     32'(q.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("irq",      32'(irq),      32'(q.size() >= IRQ_LEVEL));
        chk("rd_word",  32'(rd_word),  32'(m_rw));
        chk("rd_data",  rd_data,       exp_d);
    endtask

    task automatic randomize_data();
        i_early = 16'($urandom); q_early = 16'($urandom);
        i_prompt = 16'($urandom); q_prompt = 16'($urandom);
        i_late = 16'($urandom); q_late = 16'($urandom);
        epoch = 11'($urandom);
    endtask

    task automatic step(input logic d, input logic f, input logic c, input logic p, input logic r);
        dump = d; flush = f; clr_ovf = c; rd_pop = p; correlator_rst = r;
        model_edge();
        @(posedge correlator_clk);
        #1;
        dump = 1'b0; flush = 1'b0; clr_ovf = 1'b0; rd_pop = 1'b0; correlator_rst = 1'b0;
        check_all();
    endtask

    task automatic pops(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic dumps(input int n);
        for (int i = 0; i < n; i++) begin randomize_data(); step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); end
    endtask

    initial begin
        // reset state
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);

        // single record, read through all four words
        randomize_data();
        i_early = 16'h1234; q_early = 16'hABCD; epoch = 11'h155;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("first_w0", rd_data, 32'h1234ABCD);
        chk("first_irq", 32'(irq), 32'd1);
        chk("first_level", 32'(level), 32'd1);
        pops(3);
        chk("first_w3", rd_data, 32'h00000155);
        pops(1);

        // pop while empty is ignored and outputs stay known
        pops(2);
        chk("empty_pop_word", 32'(rd_word), 32'd0);
        chk("empty_pop_x", 32'(^{rd_data, rd_word, level, empty, full, overflow, irq} === 1'bx), 32'd0);

        // nine dumps into eight slots
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        dumps(9);
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_level", 32'(level), 32'd8);
        pops(7 * 4 + 3);
        chk("eighth_seq", 32'(rd_data[15:11]), 32'd7);
        pops(1);
        dumps(1);
        pops(3);
        chk("after_drop_seq", 32'(rd_data[15:11]), 32'd9);
        pops(1);

        // dump while full coinciding with the head's final pop
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        dumps(8);
        pops(3);
        randomize_data();
        saved_i = i_early; saved_q = q_early;
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("swap_level", 32'(level), 32'd8);
        chk("swap_ovf", 32'(overflow), 32'd0);
        pops(7 * 4);
        chk("swap_tail", rd_data, {saved_i, saved_q});
        pops(4);

        // flush with 3 records, mid-record, concurrent dump, overflow kept
        dumps(9);
        pops(5 * 4 + 2);
        chk("pre_flush_level", 32'(level), 32'd3);
        chk("pre_flush_word", 32'(rd_word), 32'd2);
        randomize_data();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_word", 32'(rd_word), 32'd0);
        chk("flush_ovf", 32'(overflow), 32'd1);
        dumps(1);
        pops(3);
        chk("flush_seq", 32'(rd_data[15:11]), 32'd0);

        // reset mid-record with overflow set
        dumps(2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_word", 32'(rd_word), 32'd3);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("rst_mid", {rd_data[25:0], rd_word, level[2:0], empty}, {26'h0, 2'd0, 3'd0, 1'b1});
        chk("rst_flags", {29'h0, full, overflow, irq}, 32'h0);
        dumps(1);
        pops(3);
        chk("rst_seq", 32'(rd_data[15:11]), 32'd0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            randomize_data();
            step(1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 2),
                 1'($urandom_range(0, 99) < 5), 1'($urandom_range(0, 99) < 60),
                 1'($urandom_range(0, 199) < 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/gps_dump_buffer.md
GPS_DUMP_BUFFER -- requirements
Module: gps_dump_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of record slots (power of two, 2..32).
REQ-002 SHALL have parameter IRQ_LEVEL, default 1, meaning occupancy at or above which irq asserts (1..DEPTH).
REQ-003 SHALL have port correlator_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port correlator_rst, input, 1, reset; it is synchronous and active-high.
REQ-005 SHALL have port dump, input, 1, single-cycle pulse from the tracking channel marking valid accumulations.
REQ-006 SHALL have ports i_early, q_early, i_prompt, q_prompt, i_late, q_late, input, 16 each, the accumulation values, sampled in the dump cycle.
REQ-007 SHALL have port epoch, input, 11, the channel epoch count, sampled in the dump cycle.
REQ-008 SHALL have port flush, input, 1, a synchronous clear of buffer contents.
REQ-009 SHALL have port clr_ovf, input, 1, which clears the overflow flag.
REQ-010 SHALL have port rd_pop, input, 1, which consumes the current read word.
REQ-011 SHALL have port rd_data, output, 32, the current word of the head record.
REQ-012 SHALL have port rd_word, output, 2, the index of the current word within the head record.
REQ-013 SHALL have port level, output, 6, the number of complete records held.
REQ-014 SHALL have ports empty, full, output, 1 each, the status flags.
REQ-015 SHALL have port overflow, output, 1, a sticky flag meaning at least one dump was dropped.
REQ-016 SHALL have port irq, output, 1, level-sensitive interrupt, high while level >= IRQ_LEVEL.

Function
REQ-017 SHALL write one record per dump pulse, in the same clock edge, when not full or when a retire occurs in that same cycle.
REQ-018 SHALL form each record as 4 words:
  - W0 = {i_early, q_early}
  - W1 = {i_prompt, q_prompt}
  - W2 = {i_late, q_late}
  - W3 = {16'h0, seq[4:0], epoch[10:0]}
REQ-019 SHALL keep seq as a 5-bit dump counter that increments on every dump pulse (accepted or dropped) and wraps 31->0, so firmware can detect gaps.
REQ-020 SHALL drive rd_data combinationally from the head record, selected by rd_word; rd_data is 0 when empty.
REQ-021 SHALL handle rd_pop while not empty as follows:
  - rd_word 0->1->2->3 advances one step per pop.
  - A pop at rd_word==3 retires the head record and sets rd_word to 0.
REQ-022 SHALL ignore rd_pop while empty, with no state change.
REQ-023 SHALL update level as follows:
  - +1 on an accepted write without a retire.
  - -1 on a retire without a write.
  - Unchanged on a simultaneous write and retire, including when full.
REQ-024 SHALL define empty = (level==0) and full = (level==DEPTH).
REQ-025 SHALL drop the dump when it arrives while full with no same-cycle retire; it then sets overflow and leaves contents unchanged.
REQ-026 SHALL keep overflow set until clr_ovf; if clr_ovf and a dropped dump occur in the same cycle, overflow is set.
REQ-027 SHALL, on flush, clear the following at the next edge:
  - level and the read/write pointers
  - rd_word and seq
  - overflow is not affected by flush.
REQ-028 SHALL ignore a dump in the flush cycle (not written); seq is 0 after that cycle.
REQ-029 SHALL implement the pointers as log2(DEPTH)-bit counters that wrap naturally.

Reset
REQ-030 SHALL, while correlator_rst is high at a clock edge, produce: level=0, empty=1, full=0, overflow=0, irq=0, rd_word=0, seq=0, rd_data=0.
REQ-031 SHALL give reset priority over flush, dump and rd_pop; record storage need not be cleared.
REQ-032 SHALL, on reset mid-record (rd_word!=0), discard the partially read record.

Verification
REQ-033 SHALL cover: dump with i_early=16'h1234, q_early=16'hABCD, epoch=11'h155 -> next cycle level=1, irq=1, rd_data=32'h1234ABCD; after 3 pops rd_data=32'h00000155 with seq=0.
REQ-034 SHALL cover: 9 dumps with no pops (DEPTH=8) -> full=1, overflow=1, level=8; the 8th record's W3 seq=7, and the next dump after draining carries seq=9.
REQ-035 SHALL cover: when full, dump together with the 4th pop of the head -> level stays 8, overflow stays 0, and the new record sits at the tail.
REQ-036 SHALL cover: rd_pop while empty -> rd_word=0, level=0, and no X on any output.
REQ-037 SHALL cover: flush with 3 records held, rd_word=2 and a concurrent dump -> next cycle level=0, rd_word=0, seq=0, overflow unchanged.
REQ-038 SHALL cover: correlator_rst asserted mid-record with overflow=1 -> all outputs at REQ-030 values one edge later.
